// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug command bridge: IR codes and
// default command geometry.
package nios2_debug_pkg;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_code_e;

    localparam int DEFAULT_IR_WIDTH   = 2;
    localparam int DEFAULT_DR_WIDTH   = 38;
    localparam int DEFAULT_ACTION_BIT = 34;

    // Pointer/level width for a power-of-two queue: one extra bit tells full from empty.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Synchronises one TCK-domain strobe into clk and emits a one-cycle pulse on
// each rising edge, ignoring a strobe that was already high across reset.
module nios2_debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic                   prev_q, prev_d;
    logic                   lvl;

    assign lvl = sync_q[SYNC_STAGES-1];

    // fill_q marks when the chain holds real samples rather than reset zeros,
    // so the detector only arms on a genuinely observed low level.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~lvl);
        prev_d  = lvl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            prev_q  <= prev_d;
        end
    end

    assign evt = armed_q & lvl & ~prev_q;

endmodule

// File: rtl/nios2_debug_cmd_bridge.sv
// System-clock side of the JTAG debug slave: turns update-IR/update-DR strobes
// into queued {ir, data} command words with ready/valid and sticky overflow.
module nios2_debug_cmd_bridge
    import nios2_debug_pkg::*;
#(
    parameter int IR_WIDTH    = DEFAULT_IR_WIDTH,
    parameter int DR_WIDTH    = DEFAULT_DR_WIDTH,
    parameter int ACTION_BIT  = DEFAULT_ACTION_BIT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 vs_uir,
    input  logic                                 vs_udr,
    input  logic [IR_WIDTH-1:0]                  ir_in,
    input  logic [DR_WIDTH-1:0]                  sr,
    output logic                                 cmd_valid,
    input  logic                                 cmd_ready,
    output logic [IR_WIDTH-1:0]                  cmd_ir,
    output logic [DR_WIDTH-1:0]                  cmd_data,
    output logic                                 cmd_action,
    output logic [$clog2(FIFO_DEPTH):0]          cmd_level,
    output logic                                 ovf,
    input  logic                                 ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = level_width(FIFO_DEPTH);
    localparam int EW = IR_WIDTH + DR_WIDTH;

    logic                uir_evt, udr_evt;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       level_q, level_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                pop, full, push_ok, drop;
    logic [EW-1:0]       head;

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .evt      (uir_evt)
    );

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .evt      (udr_evt)
    );

    // A push into a full queue survives only if the head leaves in the same cycle.
    // The pushed entry deliberately uses the IR captured before this cycle.
    always_comb begin
        pop     = valid_q & cmd_ready;
        full    = (level_q == PW'(FIFO_DEPTH));
        push_ok = udr_evt & (~full | pop);
        drop    = udr_evt & full & ~pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = {ir_q, sr};
        end

        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop);
        level_d = wr_d - rd_d;
        valid_d = (level_d != '0);
        ir_d    = uir_evt ? ir_in : ir_q;
        ovf_d   = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ir_q    <= ir_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign head       = mem_q[rd_q[AW-1:0]];
    assign cmd_ir     = head[EW-1 -: IR_WIDTH];
    assign cmd_data   = head[DR_WIDTH-1:0];
    assign cmd_action = head[ACTION_BIT];
    assign cmd_valid  = valid_q;
    assign cmd_level  = level_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_nios2_debug_cmd_bridge.sv
// Randomised and directed bench for nios2_debug_cmd_bridge against a
// queue-level command model.
module tb_nios2_debug_cmd_bridge;

    localparam int IRW   = 2;
    localparam int DRW   = 38;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int EW    = IRW + DRW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           vs_uir = 1'b0;
    logic           vs_udr = 1'b0;
    logic [IRW-1:0] ir_in = '0;
    logic [DRW-1:0] sr = '0;
    logic           cmd_ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           cmd_valid;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic           cmd_action;
    logic [2:0]     cmd_level;
    logic           ovf;

    nios2_debug_cmd_bridge #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .ACTION_BIT(34),
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_action(cmd_action),
        .cmd_level(cmd_level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int dut_pops = 0;
    bit rand_ready = 1'b0;

    // Reference model: command queue, captured IR, overflow flag and a
    // per-strobe countdown from first high sample to the event edge.
    logic [EW-1:0] exp_q[$];
    logic [IRW-1:0] ir_m = '0;
    logic ovf_m = 1'b0;
    logic arm_u = 1'b0, arm_d = 1'b0, prev_u = 1'b1, prev_d = 1'b1;
    int cnt_u = 0, cnt_d = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic strobe_model(input logic lvl, inout logic armed, inout logic prev,
                                inout int cnt, output logic fire);
        fire = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) fire = 1'b1;
        end
        if (armed && lvl && !prev) cnt = SYNC;
        if (!lvl) armed = 1'b1;
        prev = lvl;
    endtask

    task automatic step();
        logic          stall;
        logic [EW-1:0] head_before;
        logic          fu, fd, pop_m, drop_m;
        logic [EW-1:0] h;
        stall = cmd_valid && !cmd_ready;
        head_before = {cmd_ir, cmd_data};
        if (cmd_valid && cmd_ready) dut_pops++;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            ir_m = '0; ovf_m = 1'b0;
            arm_u = 1'b0; arm_d = 1'b0; prev_u = 1'b1; prev_d = 1'b1;
            cnt_u = 0; cnt_d = 0;
        end else begin
            strobe_model(vs_uir, arm_u, prev_u, cnt_u, fu);
            strobe_model(vs_udr, arm_d, prev_d, cnt_d, fd);
            pop_m = (exp_q.size() > 0) && cmd_ready;
            if (pop_m) void'(exp_q.pop_front());
            drop_m = 1'b0;
            if (fd) begin
                if (exp_q.size() == DEPTH) drop_m = 1'b1;
                else exp_q.push_back({ir_m, sr});
            end
            if (fu) ir_m = ir_in;
            if (drop_m) ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
        end
        #1;
        chk("valid", 64'(cmd_valid), 64'(exp_q.size() > 0));
        chk("level", 64'(cmd_level), 64'(exp_q.size()));
        chk("ovf", 64'(ovf), 64'(ovf_m));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("head_ir", 64'(cmd_ir), 64'(h[EW-1 -: IRW]));
            chk("head_data", 64'(cmd_data), 64'(h[DRW-1:0]));
            chk("head_action", 64'(cmd_action), 64'(h[34]));
        end
        if (stall && !reset) chk("head_stable", 64'({cmd_ir, cmd_data}), 64'(head_before));
        if (rand_ready) cmd_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic pulse_uir(input logic [IRW-1:0] v);
        ir_in = v; vs_uir = 1'b1;
        repeat (SYNC + 1) step();
        vs_uir = 1'b0;
        repeat (SYNC + 1) step();
    endtask

    task automatic pulse_udr(input logic [DRW-1:0] d);
        sr = d; vs_udr = 1'b1;
        repeat (SYNC + 1) step();
        vs_udr = 1'b0;
        repeat (SYNC + 1) step();
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        repeat (DEPTH + 1) step();
        cmd_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] r;

        // Reset state
        repeat (3) step();
        chk("rst_valid", 64'(cmd_valid), 0);
        chk("rst_level", 64'(cmd_level), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_ir", 64'(cmd_ir), 0);
        chk("rst_data", 64'(cmd_data), 0);
        chk("rst_action", 64'(cmd_action), 0);
        reset = 1'b0;
        repeat (4) step();

        // Basic IR capture, DR push and latency
        pulse_uir(2'd2);
        sr = 38'h04_0000_1234; vs_udr = 1'b1;
        step(); chk("t1_lat1", 64'(cmd_valid), 0);
        step(); chk("t1_lat2", 64'(cmd_valid), 0);
        step(); chk("t1_lat3", 64'(cmd_valid), 1);
        chk("t1_ir", 64'(cmd_ir), 2);
        chk("t1_data", 64'(cmd_data), 64'h04_0000_1234);
        chk("t1_action", 64'(cmd_action), 1);
        chk("t1_level", 64'(cmd_level), 1);
        vs_udr = 1'b0;
        repeat (SYNC + 1) step();
        drain();

        // Overflow and in-order drain
        for (int i = 1; i <= 5; i++) pulse_udr(DRW'(i));
        chk("t2_level", 64'(cmd_level), 4);
        chk("t2_ovf", 64'(ovf), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", 64'(cmd_data), 64'(i));
            cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        end
        chk("t2_empty", 64'(cmd_level), 0);
        chk("t2_ovf_sticky", 64'(ovf), 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("t2_ovf_clr", 64'(ovf), 0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) pulse_udr(DRW'(11 + i));
        chk("t3_full", 64'(cmd_level), 4);
        sr = DRW'(15); vs_udr = 1'b1;
        step(); step();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk("t3_level", 64'(cmd_level), 4);
        chk("t3_ovf", 64'(ovf), 0);
        chk("t3_head", 64'(cmd_data), 12);
        vs_udr = 1'b0;
        repeat (SYNC + 1) step();
        drain();

        // Strobe held high across reset
        sr = DRW'(21); vs_udr = 1'b1; reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        repeat (4) step();
        chk("t4_no_entry", 64'(cmd_level), 0);
        vs_udr = 1'b0; repeat (3) step();
        vs_udr = 1'b1; repeat (3) step();
        vs_udr = 1'b0; repeat (3) step();
        chk("t4_one_entry", 64'(cmd_level), 1);
        chk("t4_data", 64'(cmd_data), 21);
        drain();

        // Simultaneous IR and DR events
        pulse_uir(2'd1);
        ir_in = 2'd3; sr = 38'h3B_0000_00AA;
        vs_uir = 1'b1; vs_udr = 1'b1;
        repeat (SYNC + 1) step();
        vs_uir = 1'b0; vs_udr = 1'b0;
        repeat (SYNC + 1) step();
        chk("t5_old_ir", 64'(cmd_ir), 1);
        chk("t5_action", 64'(cmd_action), 0);
        pulse_udr(38'h04_0000_0001);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk("t5_new_ir", 64'(cmd_ir), 3);
        drain();

        // Random backpressure with mixed commands
        dut_pops = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) pulse_uir(IRW'($urandom_range(0, 3)));
            r = {$urandom(), $urandom()};
            pulse_udr(r[DRW-1:0]);
        end
        rand_ready = 1'b0;
        cmd_ready = 1'b1;
        repeat (8) step();
        cmd_ready = 1'b0;
        step();
        chk("t6_pop_count", 64'(dut_pops), 10);
        chk("t6_ovf", 64'(ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios2_debug_cmd_bridge.md
# nios2_debug_cmd_bridge

Parametrised system-clock side of the Nios II JTAG debug slave: synchronises the virtual-JTAG update-IR/update-DR strobes into `clk`, captures the instruction and shift-register contents, and queues them as command words in a small FIFO with a ready/valid output. It replaces the fixed 2-bit-IR, 38-bit, single-register sysclk decoder. Commands are buffered instead of overwritten, overflow is reported, and IR/DR widths and queue depth are generic. It sits between the TCK-domain shift logic and the OCI command consumers (ocimem, break, tracectrl).

## Interface
Parameters:
- `IR_WIDTH`, 2: virtual IR width.
- `DR_WIDTH`, 38: shift-register / command data width.
- `ACTION_BIT`, 34: index in data that distinguishes take_action (1) from take_no_action (0); must be < DR_WIDTH.
- `FIFO_DEPTH`, 4: command queue entries; power of 2, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops per strobe; ≥ 2.

Ports:
- `clk` in 1: system clock. Single clock domain for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `vs_uir` in 1: update-IR level from the TCK domain; asynchronous to `clk`.
- `vs_udr` in 1: update-DR level from the TCK domain; asynchronous to `clk`.
- `ir_in` in IR_WIDTH: virtual IR value; quasi-static around `vs_uir`.
- `sr` in DR_WIDTH: shift-register contents; quasi-static around `vs_udr`.
- `cmd_valid` out 1: queue head is valid.
- `cmd_ready` in 1: consumer accepts the head.
- `cmd_ir` out IR_WIDTH: IR field of the head.
- `cmd_data` out DR_WIDTH: data field of the head (legacy `jdo`).
- `cmd_action` out 1: `cmd_data[ACTION_BIT]`.
- `cmd_level` out $clog2(FIFO_DEPTH)+1: number of queued entries.
- `ovf` out 1: sticky overflow flag.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Each strobe passes through a SYNC_STAGES flop chain, then a rising-edge detector (`uir_evt`, `udr_evt`: one-cycle pulses).
- Arm rule: an edge detector is disarmed out of reset. It arms on the first cycle its synchronised level is 0. A strobe held high across reset therefore produces no event.
- `uir_evt`: `ir_q <= ir_in`.
- `udr_evt`: push the entry `{ir_q, sr}`. `sr` is sampled in the event cycle.
- Simultaneous `uir_evt` and `udr_evt`: the pushed entry uses the old `ir_q`; `ir_q` updates in the same cycle.
- Pop: occurs when `cmd_valid && cmd_ready`.
- Full with push and no pop: the entry is dropped, `ovf` is set, and the FIFO is unchanged.
- Full with push and pop in the same cycle: both are accepted; level stays FIFO_DEPTH.
- Empty: `cmd_valid` = 0 and `cmd_ready` is ignored. No bypass; a push into an empty FIFO is visible the next cycle.
- `ovf_clr` together with a new overflow in the same cycle: `ovf` stays 1 (set wins).
- Read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide, wrap modulo 2·FIFO_DEPTH, and level = wr − rd.
- Outputs are registered or driven directly from registered FIFO storage. The head is stable while `cmd_valid && !cmd_ready`.

## Timing
- Reset values: `cmd_valid`=0, `cmd_level`=0, `ovf`=0, `ir_q`=0. `cmd_ir`/`cmd_data`/`cmd_action` show storage slot 0, which resets to 0. All sync flops are 0 and both detectors are disarmed.
- Reset mid-operation: all queued entries are discarded. Any in-flight strobe is lost unless its level falls and rises again after reset.
- Latency: `vs_udr` first sampled high at edge k → push at edge k+SYNC_STAGES → `cmd_valid`=1 after that edge. That is SYNC_STAGES+1 clocks; 3 for the default.
- Source requirement: `sr` and `ir_in` are stable from the strobe rise until SYNC_STAGES+2 clk cycles later. Each strobe is high and low for at least SYNC_STAGES+1 clk cycles.
- Throughput: one pop per cycle. At most one push per SYNC_STAGES+1 cycles, per the source requirement.

## Structure
- Package `nios2_debug_pkg`:
  - IR code constants: `IR_OCIMEM`=0, `IR_TRACEMEM`=1, `IR_BREAK`=2, `IR_TRACECTRL`=3.
  - Defaults for DR_WIDTH and ACTION_BIT.
- Sub-module `nios2_debug_sync_edge` (param SYNC_STAGES):
  - Contains the synchroniser, arm flag and rising-edge pulse.
  - Instantiated twice, once for `vs_uir` and once for `vs_udr`.
- FIFO storage and pointers are inline in the top module.

## Test plan
- Reset, then `vs_uir` rise with `ir_in`=2, then `vs_udr` rise with `sr`=38'h04_0000_1234, `cmd_ready`=0 → `cmd_valid` is high exactly 3 clocks after the first high sample of `vs_udr`, with `cmd_ir`=2, `cmd_data`=38'h04_0000_1234, `cmd_action`=1 and `cmd_level`=1.
- 5 `vs_udr` pulses with `sr`=1..5 and `cmd_ready`=0 → level saturates at 4 and `ovf`=1. Draining gives `cmd_data` 1,2,3,4 in order; `ovf_clr` then gives `ovf`=0.
- FIFO full with `cmd_ready`=1 held during a push → the push is accepted, level stays 4 and `ovf` stays 0.
- `vs_udr` held high through a 4-cycle reset pulse → no entry is queued. Drop the strobe low for 3 clocks, raise it again → exactly one entry.
- `vs_uir` with `ir_in`=3 and `vs_udr` with `sr` bit 34=0 synchronised into the same cycle, previous `ir_q`=1 → entry has `cmd_ir`=1 and `cmd_action`=0. The next `udr` entry has `cmd_ir`=3.
- 10 back-to-back commands with random `cmd_ready` backpressure → scoreboard shows order preserved, no loss, and a stable head while stalled.
